clk_gate_ctrl: RTL and testbench
================================

Name: clk_gate_ctrl

Overview:
- Controller that drives the enable input of a latch-based clock gate in front of a shared, clock-gated resource (e.g. the ALU or register-file domain).
- Arbitrates NUM_REQ requesters round-robin for that resource.
- Sequences gate wake-up: the gated clock runs WAKE_CYCLES before the first grant.
- Holds the clock IDLE_CYCLES after the last request before shutting it off.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WAKE_CYCLES, 2, cycles CLK_EN is high before the first grant after OFF (>=1).
- IDLE_CYCLES, 8, idle cycles with no request before CLK_EN drops (>=1).
- CNT_WIDTH, 4, counter width; must hold max(WAKE_CYCLES, IDLE_CYCLES)-1.

Ports:
- CLK  input  1  system clock (ungated).
- RST  input  1  asynchronous, active-high reset.
- REQ  input  NUM_REQ  per-requester request level; held until the requester's work is done.
- FORCE_ON  input  1  test/debug override: keep gated clock running.
- CLK_EN  output  1  registered enable to the clock-gate cell.
- GNT  output  NUM_REQ  registered one-hot grant (all zero when none).
- GNT_VLD  output  1  OR of GNT.
- GATE_ON  output  1  high in every state except OFF (status).

Behaviour:
- All outputs are registered, with no combinational path from input to output.
- Async reset:
  - state=OFF, CLK_EN=0, GNT=0, GNT_VLD=0, GATE_ON=0, counter=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - Reset asserted mid-operation drops CLK_EN and GNT immediately.
- States:
  - OFF: CLK_EN=0.
  - WAKE: CLK_EN=1, counting down.
  - ON: CLK_EN=1, exactly one GNT bit set.
  - HOLD: CLK_EN=1, idle countdown, GNT=0.
- OFF: |REQ or FORCE_ON sampled -> WAKE, counter loaded with WAKE_CYCLES-1.
- WAKE:
  - Lasts exactly WAKE_CYCLES cycles: counter!=0 -> decrement; counter==0 -> exit.
  - On exit: |REQ -> ON with arbitrated grant; otherwise -> HOLD, counter loaded with IDLE_CYCLES-1.
  - Request latency from OFF: REQ sampled at edge k -> GNT visible after edge k+WAKE_CYCLES.
- Arbitration:
  - Round-robin, searching from index ptr upward with wrap-around; first set REQ wins.
  - On each new grant, ptr = granted index + 1, wrapping at NUM_REQ.
- ON:
  - Grant is sticky: GNT stays on owner while REQ[owner]=1; other requests are ignored.
  - REQ[owner] sampled low: if other REQ bits set, GNT moves at the same edge to the next RR winner (zero-bubble handover).
  - REQ[owner] low and no other REQ: -> HOLD, GNT=0, counter=IDLE_CYCLES-1.
- HOLD:
  - |REQ -> ON with arbitrated grant at the next edge. No wake delay, since the clock is already running.
  - FORCE_ON=1 -> counter reloads to IDLE_CYCLES-1, stay in HOLD.
  - Else counter!=0 -> decrement.
  - Else (counter==0) -> OFF, CLK_EN=0. HOLD lasts exactly IDLE_CYCLES cycles without requests.
- FORCE_ON:
  - Never alters GNT or arbitration.
  - Blocks any entry into OFF.
  - Asserted in OFF it triggers WAKE like a request.
- Simultaneous events:
  - REQ arriving on the same edge the HOLD counter expires -> ON (request wins, no OFF).
  - REQ dropping during WAKE -> re-evaluated at WAKE exit only.
- CLK_EN changes only on CLK rising edge. The gate's low-phase latch guarantees a glitch-free GATED_CLK.
- Counter uses CNT_WIDTH bits unsigned and never underflows (saturates at 0).

Test Plan:
- Reset/idle: RST=1 then released, REQ=0, FORCE_ON=0 for 20 cycles -> CLK_EN=0, GNT=0000, GATE_ON=0 throughout; reset pulse asserted mid-ON -> CLK_EN and GNT drop immediately, asynchronously.
- Wake latency: REQ=0001 sampled at edge k -> CLK_EN=1 after edge k; GNT=0001 after edge k+2 (WAKE_CYCLES=2); GNT_VLD=1.
- Round-robin: REQ=1111 from OFF -> grants 0001, 0010, 0100, 1000, 0001 as each owner drops REQ for one cycle; handover has no GNT=0 cycle.
- Idle hold: single request released at edge m -> GNT=0 after m, CLK_EN stays 1 for exactly 8 cycles, CLK_EN=0 after edge m+8; new REQ at cycle m+5 -> GNT next edge, no wake delay.
- Boundary: REQ asserted on the same edge the HOLD counter reaches 0 -> state ON, CLK_EN never drops; REQ pulse dropped during WAKE -> enters HOLD, then OFF after 8 cycles.
- FORCE_ON: FORCE_ON=1 with REQ=0 from OFF -> CLK_EN=1 after 1 edge, stays 1 for 100 cycles, GNT=0000; FORCE_ON released -> CLK_EN=0 exactly 8 cycles later.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a latch-based clock gate: round-robin grant of a shared
// gated resource with wake-up sequencing and idle hold-off before shutdown.
module clk_gate_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               FORCE_ON,
  output logic               CLK_EN,
  output logic [NUM_REQ-1:0] GNT,
  output logic               GNT_VLD,
  output logic               GATE_ON
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] WAKE_LOAD = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_HOLD} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 clk_en_q, clk_en_d;
  logic                 gnt_vld_q, gnt_vld_d;
  logic                 gate_on_q, gate_on_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]     arb_ptr;
  logic                 any_req;
  logic                 owner_req;

  assign any_req   = |REQ;
  assign owner_req = |(REQ & gnt_q);

  // Round-robin search starting at ptr_q; the pointer moves past the winner.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    found   = 1'b0;
    idx     = '0;
    arb_gnt = '0;
    arb_ptr = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && REQ[idx]) begin
        found        = 1'b1;
        arb_gnt[idx] = 1'b1;
        arb_ptr      = PTR_W'((32'(idx) + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      clk_en_q  <= 1'b0;
      gnt_vld_q <= 1'b0;
      gate_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      clk_en_q  <= clk_en_d;
      gnt_vld_q <= gnt_vld_d;
      gate_on_q <= gate_on_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      S_OFF: begin
        gnt_d = '0;
        if (any_req || FORCE_ON) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      S_WAKE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (any_req) begin
          state_d = S_ON;
          gnt_d   = arb_gnt;
          ptr_d   = arb_ptr;
        end else begin
          state_d = S_HOLD;
          cnt_d   = IDLE_LOAD;
        end
      end
      S_ON: begin
        // Owner keeps the grant while its request stays high.
        if (!owner_req) begin
          if (any_req) begin
            gnt_d = arb_gnt;
            ptr_d = arb_ptr;
          end else begin
            state_d = S_HOLD;
            gnt_d   = '0;
            cnt_d   = IDLE_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (any_req) begin
          state_d = S_ON;
          gnt_d   = arb_gnt;
          ptr_d   = arb_ptr;
        end else if (FORCE_ON) begin
          cnt_d = IDLE_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_OFF;
        end
      end
      default: begin
        state_d = S_OFF;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    clk_en_d  = (state_d != S_OFF);
    gate_on_d = (state_d != S_OFF);
    gnt_vld_d = |gnt_d;
  end

  assign CLK_EN  = clk_en_q;
  assign GNT     = gnt_q;
  assign GNT_VLD = gnt_vld_q;
  assign GATE_ON = gate_on_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: a cycle-level reference model pushes the
// expected outputs after each edge, a monitor pops and compares on the falling edge.
module tb_clk_gate_ctrl;

  localparam int NR   = 4;
  localparam int WAKE = 2;
  localparam int IDLE = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [NR-1:0] REQ = '0;
  logic          FORCE_ON = 1'b0;
  logic          CLK_EN;
  logic [NR-1:0] GNT;
  logic          GNT_VLD;
  logic          GATE_ON;

  clk_gate_ctrl #(
    .NUM_REQ    (NR),
    .WAKE_CYCLES(WAKE),
    .IDLE_CYCLES(IDLE),
    .CNT_WIDTH  (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .FORCE_ON(FORCE_ON),
    .CLK_EN  (CLK_EN),
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .GATE_ON (GATE_ON)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          clk_en;
    logic [NR-1:0] gnt;
    logic          gnt_vld;
    logic          gate_on;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  // Reference model: gate running flag, wake edges left, idle edges left, owner (-1 = none).
  bit m_run;
  int m_wake, m_idle, m_owner, m_ptr;

  always @(posedge CLK) cycle++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wake = 0; m_idle = 0; m_owner = -1; m_ptr = 0;
  endtask

  task automatic pick(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (r[k]) begin
        m_owner = k;
        m_ptr   = (k + 1) % NR;
        return;
      end
    end
  endtask

  task automatic model_step(input logic [NR-1:0] r, input logic f);
    if (!m_run) begin
      if (r != 0 || f) begin
        m_run = 1; m_wake = WAKE; m_owner = -1;
      end
    end else if (m_wake > 0) begin
      m_wake--;
      if (m_wake == 0) begin
        if (r != 0) pick(r);
        else m_idle = IDLE;
      end
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        if (r != 0) pick(r);
        else begin m_owner = -1; m_idle = IDLE; end
      end
    end else begin
      if (r != 0) pick(r);
      else if (f) m_idle = IDLE;
      else begin
        m_idle--;
        if (m_idle == 0) m_run = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.clk_en  = m_run;
    e.gate_on = m_run;
    e.gnt     = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
    e.gnt_vld = (m_owner >= 0);
    return e;
  endfunction

  task automatic step(input logic [NR-1:0] r, input logic f);
    REQ = r;
    FORCE_ON = f;
    @(posedge CLK);
    model_step(r, f);
    sb.push_back(model_out());
    #1;
  endtask

  task automatic apply_reset(input bit check_now);
    REQ = '0;
    FORCE_ON = 1'b0;
    RST = 1'b1;
    #1;
    if (check_now) begin
      chk("async_rst_clk_en", 32'(CLK_EN), 32'(0));
      chk("async_rst_gnt", 32'(GNT), 32'(0));
    end
    model_reset();
    sb.delete();
    repeat (2) begin
      @(posedge CLK);
      sb.push_back(model_out());
    end
    #1;
    RST = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("clk_en",  32'(CLK_EN),  32'(mon_e.clk_en));
        chk("gnt",     32'(GNT),     32'(mon_e.gnt));
        chk("gnt_vld", 32'(GNT_VLD), 32'(mon_e.gnt_vld));
        chk("gate_on", 32'(GATE_ON), 32'(mon_e.gate_on));
      end
    end
  end

  initial begin
    logic [NR-1:0] r;
    logic          f;

    apply_reset(0);
    repeat (20) step('0, 1'b0);

    // Wake latency, then release into idle hold and shutdown
    repeat (5) step(4'b0001, 1'b0);
    repeat (12) step('0, 1'b0);

    // Round-robin rotation with one-cycle owner drops
    for (int i = 0; i < 10 && m_owner < 0; i++) step(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      r = 4'b1111;
      if (m_owner >= 0) r[m_owner] = 1'b0;
      step(r, 1'b0);
      step(4'b1111, 1'b0);
    end
    repeat (12) step('0, 1'b0);

    // New request during idle hold: granted without wake delay
    repeat (4) step(4'b0001, 1'b0);
    repeat (5) step('0, 1'b0);
    repeat (3) step(4'b0010, 1'b0);
    repeat (12) step('0, 1'b0);

    // Request on the edge the hold count expires
    repeat (4) step(4'b0100, 1'b0);
    for (int i = 0; i < 20 && m_idle != 1; i++) step('0, 1'b0);
    repeat (3) step(4'b0100, 1'b0);
    repeat (12) step('0, 1'b0);

    // Request pulse that vanishes during wake
    step(4'b1000, 1'b0);
    repeat (12) step('0, 1'b0);

    // Force-on keeps the clock alive without grants
    repeat (100) step('0, 1'b1);
    repeat (12) step('0, 1'b0);

    // Asynchronous reset while a grant is active
    repeat (5) step(4'b0010, 1'b0);
    #2;
    apply_reset(1);
    repeat (4) step('0, 1'b0);

    // Randomized requesters that hold until served, occasional force-on
    r = '0;
    f = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (m_owner == i && $urandom_range(3) == 0) r[i] = 1'b0;
        else if (!r[i] && $urandom_range(7) == 0) r[i] = 1'b1;
      end
      if (n % 80 >= 65) r = '0;
      if ($urandom_range(39) == 0) f = ~f;
      step(r, f);
    end
    repeat (12) step('0, 1'b0);

    repeat (3) @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
